truth_table_scanner: RTL and testbench



---
 rtl/truth_table_scanner.sv | 150 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
// -------------------
// Sweeps a small combinational function through every minterm in ascending
// order, samples its output after a settle delay, and compares the captured
// truth table against an expected table.
//
// Parameters
//   N_IN    number of function inputs (1..4); M = 2**N_IN minterms
//   SETTLE  extra wait cycles after driving inputs before sampling (0..7)
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous, active-high reset
//   i_start      scan request, sampled only in IDLE
//   i_expected   expected table, bit m = expected output for minterm m
//   i_fn_s       output of the function under test
//   o_fn_in      function inputs = current minterm (MSB = a, LSB = b); 0 in IDLE
//   o_table      captured truth table, bit m = sampled i_fn_s at minterm m
//   o_busy       high from accepted start until FINISH exits
//   o_done       one-cycle completion pulse (the FINISH cycle)
//   o_pass       1 iff the last completed scan had zero mismatches
//   o_err_count  number of mismatching minterms in the last scan (0..M)
//   o_first_err  lowest mismatching minterm, 0 when none
//   o_state      current FSM state, exposed for observation
//
// Handshake: i_start is a level request honoured only while IDLE; a start
// seen in any other state is dropped, never queued. o_done is a single-cycle
// pulse and results hold afterwards until the next accepted start or reset.
module truth_table_scanner #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [(1<<N_IN)-1:0]   i_expected,
  input  logic                   i_fn_s,
  output logic [N_IN-1:0]        o_fn_in,
  output logic [(1<<N_IN)-1:0]   o_table,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [N_IN:0]          o_err_count,
  output logic [N_IN-1:0]        o_first_err,
  output logic [1:0]             o_state
);

  localparam int M = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [M-1:0]      r_exp;
  logic [M-1:0]      r_table;
  logic [N_IN-1:0]   r_m;
  logic [2:0]        r_cnt;
  logic [N_IN:0]     r_err;
  logic [N_IN-1:0]   r_first;
  logic              r_pass;

  logic              w_last;
  logic              w_mismatch;
  logic [N_IN:0]     w_err_next;

  assign w_last     = (r_m == N_IN'(M - 1));
  assign w_mismatch = (i_fn_s != r_exp[r_m]);
  assign w_err_next = r_err + (N_IN+1)'(w_mismatch);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = DRIVE;
      DRIVE:   if (r_cnt == 3'd0) w_state_next = SAMPLE;
      SAMPLE:  w_state_next = w_last ? FINISH : DRIVE;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: minterm index, settle counter, captured table and results
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exp   <= '0;
      r_table <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_exp   <= i_expected;
            r_table <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
            r_m     <= '0;
            r_cnt   <= 3'(SETTLE);
          end
        end
        DRIVE: begin
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
        SAMPLE: begin
          r_table[r_m] <= i_fn_s;
          r_err        <= w_err_next;
          // A zero running count means this is the first mismatch of the scan.
          if (w_mismatch && (r_err == '0)) r_first <= r_m;
          if (w_last) begin
            // Resolve pass on entry to FINISH so it is already valid while
            // o_done is high.
            r_pass <= (w_err_next == '0);
          end else begin
            r_m   <= r_m + N_IN'(1);
            r_cnt <= 3'(SETTLE);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fn_in     = (r_state == IDLE) ? '0 : r_m;
  assign o_table     = r_table;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == FINISH);
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_first_err = r_first;
  assign o_state     = r_state;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: an a | ~b gate is attached to two
// scanner instances (SETTLE=1 and SETTLE=0); expected values are hand-derived.
module tb_truth_table_scanner;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic       start;
  logic [3:0] expected;
  logic       fn_s;
  logic [1:0] fn_in;
  logic [3:0] tbl;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_err;
  logic [1:0] state;

  // SETTLE=0 instance
  logic       s0_start;
  logic [3:0] s0_expected;
  logic       s0_fn_s;
  logic [1:0] s0_fn_in;
  logic [3:0] s0_tbl;
  logic       s0_busy, s0_done, s0_pass;
  logic [2:0] s0_err_count;
  logic [1:0] s0_first_err;
  logic [1:0] s0_state;

  // function under test: s = a | ~b, a = MSB, b = LSB
  assign fn_s    = fn_in[1] | ~fn_in[0];
  assign s0_fn_s = s0_fn_in[1] | ~s0_fn_in[0];

  truth_table_scanner #(.N_IN(2), .SETTLE(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_expected(expected),
    .i_fn_s(fn_s), .o_fn_in(fn_in), .o_table(tbl), .o_busy(busy),
    .o_done(done), .o_pass(pass), .o_err_count(err_count),
    .o_first_err(first_err), .o_state(state)
  );

  truth_table_scanner #(.N_IN(2), .SETTLE(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_start(s0_start), .i_expected(s0_expected),
    .i_fn_s(s0_fn_s), .o_fn_in(s0_fn_in), .o_table(s0_tbl), .o_busy(s0_busy),
    .o_done(s0_done), .o_pass(s0_pass), .o_err_count(s0_err_count),
    .o_first_err(s0_first_err), .o_state(s0_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One SETTLE=1 scan. Start is sampled at edge 0; the loop index e means
  // "just after edge e". Optionally change expected after edge chg_at, and
  // re-pulse start so it is sampled at edge pulse_at (-1 = never).
  task automatic scan_main(input logic [3:0] exp_in, input int chg_at,
                           input logic [3:0] chg_val, input int pulse_at,
                           input logic [3:0] x_tbl, input logic x_pass,
                           input logic [2:0] x_err, input logic [1:0] x_first);
    expected = exp_in;
    start    = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      step();
      start = (e == pulse_at - 1);
      if (e == chg_at) expected = chg_val;
      if (e <= 11) begin
        check($sformatf("fn_in_e%0d", e), 32'(fn_in), 32'(e / 3));
        check($sformatf("busy_e%0d", e), 32'(busy), 32'd1);
        check($sformatf("done_e%0d", e), 32'(done), 32'd0);
      end else if (e == 12) begin
        check("done_e12", 32'(done), 32'd1);
        check("busy_e12", 32'(busy), 32'd1);
        check("table_done", 32'(tbl), 32'(x_tbl));
        check("pass_done", 32'(pass), 32'(x_pass));
        check("err_done", 32'(err_count), 32'(x_err));
        check("first_done", 32'(first_err), 32'(x_first));
      end else begin
        check($sformatf("done_e%0d", e), 32'(done), 32'd0);
        check($sformatf("busy_e%0d", e), 32'(busy), 32'd0);
        check($sformatf("fn_in_idle_e%0d", e), 32'(fn_in), 32'd0);
        check("table_hold", 32'(tbl), 32'(x_tbl));
        check("pass_hold", 32'(pass), 32'(x_pass));
        check("err_hold", 32'(err_count), 32'(x_err));
        check("first_hold", 32'(first_err), 32'(x_first));
      end
    end
  endtask

  // One SETTLE=0 scan: done expected just after edge 8.
  task automatic scan_s0(input logic [3:0] exp_in, input logic [3:0] x_tbl,
                         input logic x_pass, input logic [2:0] x_err,
                         input logic [1:0] x_first);
    s0_expected = exp_in;
    s0_start    = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      s0_start = 1'b0;
      if (e <= 7) begin
        check($sformatf("s0_fn_in_e%0d", e), 32'(s0_fn_in), 32'(e / 2));
        check($sformatf("s0_done_e%0d", e), 32'(s0_done), 32'd0);
      end else if (e == 8) begin
        check("s0_done_e8", 32'(s0_done), 32'd1);
        check("s0_table", 32'(s0_tbl), 32'(x_tbl));
        check("s0_pass", 32'(s0_pass), 32'(x_pass));
        check("s0_err", 32'(s0_err_count), 32'(x_err));
        check("s0_first", 32'(s0_first_err), 32'(x_first));
      end else begin
        check("s0_done_e9", 32'(s0_done), 32'd0);
        check("s0_busy_e9", 32'(s0_busy), 32'd0);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    expected    = 4'b0000;
    s0_start    = 1'b0;
    s0_expected = 4'b0000;
    step();
    step();
    reset = 1'b0;
    step();

    // reset state
    check("rst_fn_in", 32'(fn_in), 32'd0);
    check("rst_table", 32'(tbl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_first", 32'(first_err), 32'd0);
    check("rst_state", 32'(state), 32'd0);

    // matching table
    scan_main(4'b1101, -1, 4'b0000, -1, 4'b1101, 1'b1, 3'd4 - 3'd4, 2'd0);
    // every minterm wrong
    scan_main(4'b0010, -1, 4'b0000, -1, 4'b1101, 1'b0, 3'd4, 2'd0);
    // only minterm 2 wrong
    scan_main(4'b1001, -1, 4'b0000, -1, 4'b1101, 1'b0, 3'd1, 2'd2);
    // expected changed mid-scan is ignored
    scan_main(4'b1101, 2, 4'b0000, -1, 4'b1101, 1'b1, 3'd0, 2'd0);
    // start re-pulsed at cycle 5 is ignored, single done
    scan_main(4'b1101, -1, 4'b0000, 5, 4'b1101, 1'b1, 3'd0, 2'd0);

    // reset while minterm 2 is being driven
    expected = 4'b1101;
    start    = 1'b1;
    step();                 // edge 0
    start = 1'b0;
    for (int i = 1; i <= 6; i++) step();
    check("mid_fn_in", 32'(fn_in), 32'd2);
    check("mid_table", 32'(tbl), 32'b0001);
    reset = 1'b1;
    step();                 // edge 7 with reset
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fn_in", 32'(fn_in), 32'd0);
    check("abort_table", 32'(tbl), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err_count), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("abort_nodone_%0d", i), 32'(done), 32'd0);
    end
    scan_main(4'b1101, -1, 4'b0000, -1, 4'b1101, 1'b1, 3'd0, 2'd0);

    // SETTLE=0 build
    scan_s0(4'b1101, 4'b1101, 1'b1, 3'd0, 2'd0);
    scan_s0(4'b1001, 4'b1101, 1'b0, 3'd1, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
